// File: rtl/demux_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_seq_pkg
// Description : Shared types and constants for the demux channel sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_seq_pkg;

    localparam int NUM_CH              = 8;
    localparam int SEL_W               = 3;
    localparam int HOLD_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRIVE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/next_ch_find.sv
`default_nettype none
// ============================================================================
// Module      : next_ch_find
// Description : Finds the lowest enabled channel above (or at) a given index.
// Revision    : 1.0 - initial release
// ============================================================================
module next_ch_find
    import demux_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [SEL_W-1:0]  i_cur,
    input  logic              i_include_cur,
    output logic              o_found,
    output logic [SEL_W-1:0]  o_idx
);

    // Scan downward so the lowest qualifying index is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && ((i > int'(i_cur)) ||
                              (i_include_cur && (i == int'(i_cur))))) begin
                o_found = 1'b1;
                o_idx   = SEL_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux_ch_sequencer_v.sv
`default_nettype none
// ============================================================================
// Module      : demux_ch_sequencer_v
// Description : Walks enabled demux channels in order, driving select + data.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_ch_sequencer_v
    import demux_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [NUM_CH-1:0] i_pattern,
    input  logic [NUM_CH-1:0] i_mask,
    output logic [SEL_W-1:0]  o_sel_code,
    output logic              o_a,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [7:0] c_hold_load = 8'(HOLD_CYCLES - 1);

    state_t              r_state;
    logic [NUM_CH-1:0]   r_pattern;
    logic [NUM_CH-1:0]   r_mask;
    logic [7:0]          r_cnt;
    logic [SEL_W-1:0]    r_sel;
    logic                r_a;
    logic                r_busy;
    logic                r_done;

    logic                w_first_found;
    logic [SEL_W-1:0]    w_first_idx;
    logic                w_next_found;
    logic [SEL_W-1:0]    w_next_idx;

    // First channel is searched on the live mask so SETUP follows the start edge.
    next_ch_find u_first_find (
        .i_mask        (i_mask),
        .i_cur         ('0),
        .i_include_cur (1'b1),
        .o_found       (w_first_found),
        .o_idx         (w_first_idx)
    );

    next_ch_find u_next_find (
        .i_mask        (r_mask),
        .i_cur         (r_sel),
        .i_include_cur (1'b0),
        .o_found       (w_next_found),
        .o_idx         (w_next_idx)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_pattern <= '0;
            r_mask    <= '0;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_a       <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_pattern <= i_pattern;
                        r_mask    <= i_mask;
                        r_busy    <= 1'b1;
                        if (w_first_found) begin
                            r_sel   <= w_first_idx;
                            r_state <= ST_SETUP;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_SETUP: begin
                    if (i_stop) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= c_hold_load;
                        r_a     <= r_pattern[r_sel];
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // Abort outranks dwell expiry.
                    if (i_stop) begin
                        r_a     <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_cnt == 8'd0) begin
                        r_a <= 1'b0;
                        if (w_next_found) begin
                            r_sel   <= w_next_idx;
                            r_state <= ST_SETUP;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sel_code = r_sel;
    assign o_a        = r_a;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule
`default_nettype wire

// File: doc/demux_ch_sequencer_v.md
# demux_ch_sequencer_v

Upstream driver for the 1-to-8 demultiplexer: latches an 8-bit pattern and channel-enable mask, then walks the enabled channels in ascending order, presenting each channel's select code and data bit for a programmable dwell. Its `o_sel_code`/`o_a` outputs connect directly to the demux `i_sel_code`/`i_a` inputs. The select code only changes while `o_a` is low, so no glitch reaches an unintended output.

## Interface

Parameters:

- `HOLD_CYCLES`, default 4: cycles `o_a` carries the data bit per channel; legal range 1–255.

Ports:

- `i_clk`, in, 1: single clock. One clock; reset is asynchronous and active-high.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_start`, in, 1: start a scan; sampled in IDLE only.
- `i_stop`, in, 1: abort the current scan; sampled in SETUP/DRIVE.
- `i_pattern`, in, 8: data bit per channel; latched on an accepted start.
- `i_mask`, in, 8: channel enable, 1 = visit; latched on an accepted start.
- `o_sel_code`, out, 3: channel select to the demux.
- `o_a`, out, 1: data to the demux.
- `o_busy`, out, 1: high from the cycle after an accepted start until DONE is left.
- `o_done`, out, 1: single-cycle completion pulse, also raised on abort.

## Operation

- States: IDLE, SETUP, DRIVE, DONE.
- **IDLE**
  - `i_start`=1: latch `i_pattern` and `i_mask`.
  - Any latched mask bit set: go to SETUP with `o_sel_code` = lowest enabled channel.
  - Mask 8'h00: go directly to DONE.
  - Otherwise hold.
- **SETUP** (1 cycle)
  - `o_a`=0; `o_sel_code` is stable at the current channel.
  - Next state is DRIVE; the dwell counter loads `HOLD_CYCLES-1`.
- **DRIVE**
  - `o_a` = latched `pattern[ch]`.
  - Counter decrements each cycle.
  - At counter 0: if another enabled channel exists above `ch`, go to SETUP with `o_sel_code` = that channel; else go to DONE.
- **DONE** (1 cycle)
  - `o_done`=1, `o_a`=0.
  - Next state is IDLE.
  - `o_sel_code` holds the last channel.
- **Abort:** `i_stop`=1 in SETUP or DRIVE forces `o_a`=0 on the next cycle and goes to DONE. It takes priority over counter expiry.
- **Ignored inputs:**
  - `i_start` outside IDLE, including in DONE; a start must be re-asserted in IDLE.
  - `i_stop` in IDLE or DONE.
  - Changes to `i_pattern`/`i_mask` after latching do not affect the scan in progress.
- **Arithmetic:**
  - Next-channel search is strictly greater than the current index, with no wrap-around. Channel 7 is always the last.
  - Dwell counter is 8 bits, unsigned.
- **Reset** (asynchronous, any state):
  - IDLE, `o_sel_code`=3'd0, `o_a`=0, `o_busy`=0, `o_done`=0.
  - Latched pattern/mask and counter cleared.

## Timing

- All outputs are registered.
- Start accepted at edge N: SETUP in cycle N+1, DRIVE in cycles N+2 … N+1+`HOLD_CYCLES`.
- Per enabled channel: 1 + `HOLD_CYCLES` cycles.
- Full scan of k channels: DONE at cycle N+1+k·(1+`HOLD_CYCLES`), IDLE one cycle later.
- Empty mask: DONE at N+1.
- `o_sel_code` changes only on SETUP entry, so `o_a` is 0 in the cycle it changes.
- Abort asserted during cycle M: DONE at M+1.

## Structure

- Shared package `demux_seq_pkg` holds:
  - state enum (IDLE/SETUP/DRIVE/DONE);
  - `NUM_CH`=8 and `SEL_W`=3;
  - default `HOLD_CYCLES`.
- One combinational sub-module, `next_ch_find`:
  - inputs: 8-bit mask, 3-bit current index, include-current flag;
  - outputs: found flag, 3-bit next index;
  - used for both the first-channel and next-channel searches.

## Test plan

- Pattern 8'b1010_0101, mask 8'hFF, `HOLD_CYCLES`=4, start at cycle 0: codes 0..7 in order, 5 cycles each; `o_a`=1 on ch0/2/5/7 in DRIVE only; `o_done` at cycle 41; `o_busy` high cycles 1–41.
- Mask 8'b1000_0010, pattern 8'hFF: only codes 1 then 7 are visited; `o_done` at cycle 11; `o_a` is 0 in both SETUP cycles.
- Mask 8'h00: `o_done` at cycle 1, `o_a` never high, `o_sel_code` stays 0.
- `i_stop` pulsed at the 2nd DRIVE cycle of ch3 with mask 8'hFF: `o_a`=0 the next cycle, `o_done` follows, channels 4–7 never selected. Second `i_start` during the scan is ignored.
- `i_rst` asserted mid-DRIVE without a clock edge: outputs go to 0 immediately. After release, the first start re-latches the new pattern/mask.
- `HOLD_CYCLES`=1, mask 8'h01: SETUP at cycle 1, DRIVE at cycle 2, `o_done` at cycle 3.
